// File: rtl/mips_instr_encoder.sv
// Encodes symbolic MIPS requests into 32-bit words and drains them through a small FIFO into imem.
// Optional macro ENC_ILLEGAL_TRAP_EN: illegal ops are dropped and flagged instead of written as NOP.
module mips_instr_encoder #(
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [4:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              base_load,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [15:0]       word_count,
  output logic              err_illegal
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [31:0]       fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q, rd_ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic [31:0]       enc_word;
  logic              enc_illegal;
  logic              fifo_full, fifo_empty, accept, push, pop;

  function automatic logic [31:0] r_word(logic [5:0] funct, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [4:0] shamt);
    return {6'h00, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  always_comb begin
    enc_word    = 32'h0000_0000;
    enc_illegal = 1'b0;
    case (req_op)
      5'd0:  enc_word = r_word(6'h20, req_rs, req_rt, req_rd, 5'd0);
      5'd1:  enc_word = r_word(6'h21, req_rs, req_rt, req_rd, 5'd0);
      5'd2:  enc_word = r_word(6'h22, req_rs, req_rt, req_rd, 5'd0);
      5'd3:  enc_word = r_word(6'h23, req_rs, req_rt, req_rd, 5'd0);
      5'd4:  enc_word = r_word(6'h24, req_rs, req_rt, req_rd, 5'd0);
      5'd5:  enc_word = r_word(6'h25, req_rs, req_rt, req_rd, 5'd0);
      5'd6:  enc_word = r_word(6'h27, req_rs, req_rt, req_rd, 5'd0);
      5'd7:  enc_word = r_word(6'h2A, req_rs, req_rt, req_rd, 5'd0);
      5'd8:  enc_word = r_word(6'h00, req_rs, req_rt, req_rd, req_shamt);
      5'd9:  enc_word = r_word(6'h02, req_rs, req_rt, req_rd, req_shamt);
      5'd10: enc_word = r_word(6'h03, req_rs, req_rt, req_rd, req_shamt);
      5'd11: enc_word = r_word(6'h08, req_rs, 5'd0, 5'd0, 5'd0);
      5'd12: enc_word = i_word(6'h0C, req_rs, req_rt, req_imm);
      5'd13: enc_word = i_word(6'h0D, req_rs, req_rt, req_imm);
      5'd14: enc_word = i_word(6'h0A, req_rs, req_rt, req_imm);
      5'd15: enc_word = i_word(6'h08, req_rs, req_rt, req_imm);
      5'd16: enc_word = i_word(6'h09, req_rs, req_rt, req_imm);
      5'd17: enc_word = i_word(6'h04, req_rs, req_rt, req_imm);
      5'd18: enc_word = i_word(6'h05, req_rs, req_rt, req_imm);
      5'd19: enc_word = i_word(6'h07, req_rs, 5'd0, req_imm);
      5'd20: enc_word = i_word(6'h01, req_rs, 5'd1, req_imm);
      5'd21: enc_word = i_word(6'h23, req_rs, req_rt, req_imm);
      5'd22: enc_word = i_word(6'h2B, req_rs, req_rt, req_imm);
      5'd23: enc_word = i_word(6'h0F, 5'd0, req_rt, req_imm);
      5'd24: enc_word = {6'h02, req_target};
      5'd25: enc_word = {6'h03, req_target};
      default: enc_illegal = 1'b1;
    endcase
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // Ready is held low while in reset, and never bypasses a full FIFO.
  assign req_ready = rst_n && !fifo_full && !base_load;
  assign accept    = req_valid && req_ready;
`ifdef ENC_ILLEGAL_TRAP_EN
  assign push      = accept && !enc_illegal;
`else
  assign push      = accept;
`endif
  assign pop       = !fifo_empty && imem_ready && !base_load;

  assign imem_we    = !fifo_empty;
  assign imem_addr  = addr_q;
  assign imem_wdata = fifo_empty ? 32'h0000_0000 : fifo_q[rd_ptr_q[PTR_W-1:0]];
  assign word_count = count_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q[PTR_W-1:0]] <= enc_illegal ? 32'h0000_0000 : enc_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= '0;
      count_q  <= 16'h0000;
    end else if (base_load) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      addr_q   <= base_addr & ~ADDR_W'(3);
      count_q  <= 16'h0000;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        addr_q   <= addr_q + ADDR_W'(4);
        if (count_q != 16'hFFFF) count_q <= count_q + 16'h0001;
      end
    end
  end

`ifdef ENC_ILLEGAL_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err_q <= 1'b0;
    else if (accept && enc_illegal)  err_q <= 1'b1;
  end
  assign err_illegal = err_q;
`else
  assign err_illegal = 1'b0;
`endif

endmodule
